// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller:
// states, opcodes, functs, ALU codes and datapath mux selects.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_JUMP    = 4'd10,
    S_JAL     = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic [1:0] SB_B    = 2'd0;
  localparam logic [1:0] SB_FOUR = 2'd1;
  localparam logic [1:0] SB_IMM  = 2'd2;
  localparam logic [1:0] SB_IMM4 = 2'd3;

  localparam logic [1:0] PCS_ALU = 2'd0;
  localparam logic [1:0] PCS_OUT = 2'd1;
  localparam logic [1:0] PCS_JMP = 2'd2;

endpackage

// File: rtl/mips_mc_control_hs_if.sv
// Controller <-> datapath/memory bundle.
// master = controller, slave = datapath side.
interface mips_mc_control_hs_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [2:0] alu_control;
  logic [1:0] pc_source;
  logic       pc_en;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_read, mem_write, iord,
    output ir_write, reg_dst, mem_to_reg,
    output alu_src_a, alu_src_b, ext_zero,
    output alu_control, pc_source, pc_en,
    output reg_write, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_read, mem_write, iord,
    input  ir_write, reg_dst, mem_to_reg,
    input  alu_src_a, alu_src_b, ext_zero,
    input  alu_control, pc_source, pc_en,
    input  reg_write, illegal, state
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// R-type funct to ALU operation; funct_valid
// flags the five supported functs.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  always_comb begin
    alu_control = ALU_AND;
    funct_valid = 1'b1;
    unique case (1'b1)
      (funct == FN_ADD): alu_control = ALU_ADD;
      (funct == FN_SUB): alu_control = ALU_SUB;
      (funct == FN_AND): alu_control = ALU_AND;
      (funct == FN_OR):  alu_control = ALU_OR;
      (funct == FN_SLT): alu_control = ALU_SLT;
      default:           funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control_hs.sv
// Multicycle MIPS control FSM with memory
// ready handshake and optional extended ops.
module mips_mc_control_hs
  import mips_mc_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ENABLE_EXT    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  mips_mc_control_hs_if.master bus
);

  state_t     st;
  state_t     nxt;
  logic       illegal_q;
  logic       rdy;
  logic [2:0] r_alu;
  logic       r_ok;
  logic       pc_en_d;
  logic       ir_write_d;
  logic       reg_write_d;
  logic       mem_write_d;

  logic op_r, op_lw, op_sw, op_beq, op_j;
  logic op_bne, op_addi, op_andi, op_ori, op_jal;

  assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  assign op_r    = bus.opcode == OP_RTYPE;
  assign op_lw   = bus.opcode == OP_LW;
  assign op_sw   = bus.opcode == OP_SW;
  assign op_beq  = bus.opcode == OP_BEQ;
  assign op_j    = bus.opcode == OP_J;
  assign op_bne  = ENABLE_EXT && bus.opcode == OP_BNE;
  assign op_addi = ENABLE_EXT && bus.opcode == OP_ADDI;
  assign op_andi = ENABLE_EXT && bus.opcode == OP_ANDI;
  assign op_ori  = ENABLE_EXT && bus.opcode == OP_ORI;
  assign op_jal  = ENABLE_EXT && bus.opcode == OP_JAL;

  mips_alu_decoder u_alu_dec (
    .funct       (bus.funct),
    .alu_control (r_alu),
    .funct_valid (r_ok)
  );

  always_comb begin
    nxt = st;
    unique case (st)
      S_FETCH:   if (rdy) nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op_lw || op_sw):   nxt = S_MEMADR;
          op_r:               nxt = S_RTYPEEX;
          (op_beq || op_bne): nxt = S_BRANCH;
          op_j:               nxt = S_JUMP;
          (op_addi || op_andi || op_ori):
                              nxt = S_IMMEX;
          op_jal:             nxt = S_JAL;
          default:            nxt = S_TRAP;
        endcase
      end
      S_MEMADR:  nxt = op_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (rdy) nxt = S_MEMWB;
      S_MEMWB:   nxt = S_FETCH;
      S_MEMWR:   if (rdy) nxt = S_FETCH;
      S_RTYPEEX: nxt = r_ok ? S_ALUWB : S_TRAP;
      S_ALUWB:   nxt = S_FETCH;
      S_BRANCH:  nxt = S_FETCH;
      S_IMMEX:   nxt = S_ALUWB;
      S_JUMP:    nxt = S_FETCH;
      S_JAL:     nxt = S_FETCH;
      S_TRAP:    nxt = S_TRAP;
      default:   nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      st <= nxt;
      if (nxt == S_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    bus.mem_read    = 1'b0;
    mem_write_d     = 1'b0;
    bus.iord        = 1'b0;
    ir_write_d      = 1'b0;
    bus.reg_dst     = RD_RT;
    bus.mem_to_reg  = M2R_ALU;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = SB_B;
    bus.ext_zero    = 1'b0;
    bus.alu_control = ALU_AND;
    bus.pc_source   = PCS_ALU;
    pc_en_d         = 1'b0;
    reg_write_d     = 1'b0;
    unique case (st)
      S_FETCH: begin
        bus.mem_read    = 1'b1;
        bus.alu_src_b   = SB_FOUR;
        bus.alu_control = ALU_ADD;
        ir_write_d      = rdy;
        pc_en_d         = rdy;
      end
      S_DECODE: begin
        bus.alu_src_b   = SB_IMM4;
        bus.alu_control = ALU_ADD;
      end
      S_MEMADR: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_src_b   = SB_IMM;
        bus.alu_control = ALU_ADD;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEMWB: begin
        bus.mem_to_reg = M2R_MDR;
        reg_write_d    = 1'b1;
      end
      S_MEMWR: begin
        mem_write_d = 1'b1;
        bus.iord    = 1'b1;
      end
      S_RTYPEEX: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = r_alu;
      end
      S_ALUWB: begin
        bus.reg_dst = op_r ? RD_RD : RD_RT;
        reg_write_d = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = ALU_SUB;
        bus.pc_source   = PCS_OUT;
        pc_en_d         = op_beq ? bus.zero : ~bus.zero;
      end
      S_IMMEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SB_IMM;
        unique case (1'b1)
          op_andi: begin
            bus.alu_control = ALU_AND;
            bus.ext_zero    = 1'b1;
          end
          op_ori: begin
            bus.alu_control = ALU_OR;
            bus.ext_zero    = 1'b1;
          end
          default: bus.alu_control = ALU_ADD;
        endcase
      end
      S_JUMP: begin
        bus.pc_source = PCS_JMP;
        pc_en_d       = 1'b1;
      end
      S_JAL: begin
        bus.pc_source  = PCS_JMP;
        pc_en_d        = 1'b1;
        bus.reg_dst    = RD_RA;
        bus.mem_to_reg = M2R_PC;
        reg_write_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset overrides the FETCH enables so nothing commits mid-reset.
  assign bus.pc_en     = pc_en_d & ~reset;
  assign bus.ir_write  = ir_write_d & ~reset;
  assign bus.reg_write = reg_write_d & ~reset;
  assign bus.mem_write = mem_write_d & ~reset;
  assign bus.illegal   = illegal_q;
  assign bus.state     = st;

endmodule
